// File: rtl/carrier_phase_scheduler.sv
// carrier_phase_scheduler: computes interleaved carrier angles, sequences ramp reset/release, and runs the carrier-0 timebase.
module carrier_phase_scheduler #(
  parameter int N_CARR = 9,
  parameter int PRD = 450,
  parameter int W = 11,
  parameter int LOAD_CYC = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                upd_req,
  input  logic [W-1:0]        offset_in,
  output logic                upd_ack,
  output logic                upd_err,
  output logic [N_CARR*W-1:0] angle_bus,
  output logic                carr_rst_n,
  output logic [W-1:0]        tb_cnt,
  output logic                sync,
  output logic                running
);
  localparam int STEP = 2 * PRD / N_CARR;
  localparam int IW = $clog2(N_CARR + 1);
  localparam int LW = $clog2(LOAD_CYC + 1);
  localparam logic [W:0] PER = (W+1)'(2 * PRD);
  localparam logic [W:0] STEP_W = (W+1)'(STEP);
  localparam logic [W-1:0] TOP = W'(2 * PRD - 1);
  localparam logic [IW-1:0] LAST = IW'(N_CARR - 1);
  localparam logic [LW-1:0] LLAST = LW'(LOAD_CYC - 1);
  typedef enum logic [2:0] {IDLE, CALC, LOAD, RUN, CALC_BG, PEND, RELOAD} state_t;
  state_t state;
  logic [W-1:0] off, acc, acc_nxt, tb_nxt;
  logic [W:0] acc_sum;
  logic [W-1:0] shadow [N_CARR];
  logic [IW-1:0] idx;
  logic [LW-1:0] lcnt;
  always_comb begin
    acc_sum = {1'b0, acc} + STEP_W;
    acc_nxt = acc_sum >= PER ? W'(acc_sum - PER) : W'(acc_sum);
    tb_nxt = tb_cnt == TOP ? '0 : tb_cnt + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      off <= '0;
      acc <= '0;
      idx <= '0;
      lcnt <= '0;
      for (int k = 0; k < N_CARR; k++) shadow[k] <= '0;
      angle_bus <= '0;
      carr_rst_n <= 1'b0;
      tb_cnt <= '0;
      upd_ack <= 1'b0;
      upd_err <= 1'b0;
      sync <= 1'b0;
      running <= 1'b0;
    end else begin
      upd_ack <= 1'b0;
      upd_err <= 1'b0;
      sync <= 1'b0;
      if (!en) begin
        state <= IDLE;
        carr_rst_n <= 1'b0;
        tb_cnt <= '0;
        running <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            state <= CALC;
            acc <= off;
            idx <= '0;
          end
          CALC, CALC_BG: begin
            shadow[idx] <= acc;
            acc <= acc_nxt;
            idx <= idx + 1'b1;
            if (state == CALC_BG) begin
              tb_cnt <= tb_nxt;
              sync <= tb_cnt == TOP;
            end
            // the last carrier is forwarded straight from acc so LOAD sees the full set
            if (idx == LAST) begin
              state <= state == CALC ? LOAD : PEND;
              lcnt <= '0;
              if (state == CALC)
                for (int k = 0; k < N_CARR; k++) angle_bus[k*W +: W] <= k == N_CARR - 1 ? acc : shadow[k];
            end
          end
          LOAD: begin
            lcnt <= lcnt + 1'b1;
            if (lcnt == LLAST) begin
              state <= RUN;
              carr_rst_n <= 1'b1;
              running <= 1'b1;
            end
          end
          RUN: begin
            tb_cnt <= tb_nxt;
            sync <= tb_cnt == TOP;
            if (upd_req && {1'b0, offset_in} < PER) begin
              off <= offset_in;
              acc <= offset_in;
              idx <= '0;
              upd_ack <= 1'b1;
              state <= CALC_BG;
            end else if (upd_req) begin
              upd_err <= 1'b1;
            end
          end
          PEND: begin
            if (tb_cnt == TOP) begin
              state <= RELOAD;
              for (int k = 0; k < N_CARR; k++) angle_bus[k*W +: W] <= shadow[k];
              carr_rst_n <= 1'b0;
              tb_cnt <= '0;
              sync <= 1'b1;
              running <= 1'b0;
            end else begin
              tb_cnt <= tb_nxt;
            end
          end
          RELOAD: begin
            state <= RUN;
            carr_rst_n <= 1'b1;
            running <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
